// File: rtl/ram_scan_pkg.sv
// Shared types and constants for the RAM scan controller and its bench.
package ram_scan_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam int SCAN_PERIOD_DEFAULT = 50_000_000;

  // A period of 1 still needs a one-bit counter.
  function automatic int cnt_width(input int period);
    return (period > 2) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/ram_scan_dp_mem.sv
// Simple dual-port memory: one write port and one registered read port.
// Reads return the old word when the write hits the same address.
module ram_scan_dp_mem #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register resets, so the array itself stays reset-free for block RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_scan_ctrl.sv
// Key-press write port plus an auto-scanning read port over a dual-port RAM.
// Define RAM_SCAN_CLEAR_EN to zero-fill the memory after every reset.
module ram_scan_ctrl
  import ram_scan_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 4,
  parameter int SCAN_PERIOD = SCAN_PERIOD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_req,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy
);

  localparam int                CNT_W    = cnt_width(SCAN_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_PERIOD - 1);
`ifdef RAM_SCAN_CLEAR_EN
  localparam state_t            RESET_STATE = CLEAR;
`else
  localparam state_t            RESET_STATE = RUN;
`endif
  localparam logic              RESET_BUSY = (RESET_STATE == CLEAR);

  state_t                  state_q, state_d;
  logic                    wr_req_q, wr_req_d;
  logic                    wr_ack_q, wr_ack_d;
  logic                    busy_q, busy_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
`ifdef RAM_SCAN_CLEAR_EN
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
`endif

  logic                    fire;
  logic                    tick;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  always_comb begin
    fire      = reset && (state_q == RUN) && wr_req && !wr_req_q;
    tick      = (state_q == RUN) && (cnt_q == CNT_LAST);
    wr_req_d  = wr_req;
    wr_ack_d  = fire;
    state_d   = state_q;
    busy_d    = 1'b0;
    cnt_d     = '0;
    rd_addr_d = '0;
    if (state_q == RUN) begin
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      rd_addr_d = tick ? rd_addr_q + 1'b1 : rd_addr_q;
    end
`ifdef RAM_SCAN_CLEAR_EN
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == '1) begin
        state_d = RUN;
      end
    end
    busy_d = (state_d == CLEAR);
`endif
  end

  // The clear sweep owns the write port until the last address is zeroed.
  always_comb begin
    mem_we    = fire;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
`ifdef RAM_SCAN_CLEAR_EN
    if (state_q == CLEAR) begin
      mem_we    = reset;
      mem_waddr = clr_addr_q;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RESET_STATE;
      wr_req_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      busy_q     <= RESET_BUSY;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
`ifdef RAM_SCAN_CLEAR_EN
      clr_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_req_q   <= wr_req_d;
      wr_ack_q   <= wr_ack_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
`ifdef RAM_SCAN_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
    end
  end

  ram_scan_dp_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (rd_addr_q),
    .rdata (rd_data)
  );

  assign wr_ack  = wr_ack_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Scoreboard bench for ram_scan_ctrl; adapts to RAM_SCAN_CLEAR_EN being set or not.
`timescale 1ns/1ps
module tb_ram_scan_ctrl;

  localparam int AW = 5;
  localparam int DW = 4;
  localparam int PERIOD = 4;
  localparam int DEPTH = 32;
`ifdef RAM_SCAN_CLEAR_EN
  localparam int CLEAR_CYCLES = DEPTH;
`else
  localparam int CLEAR_CYCLES = 0;
`endif

  typedef struct {
    logic          chk_rd;
    logic [DW-1:0] rd;
    logic [AW-1:0] addr;
    logic          ack;
    logic          busy;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_req = 1'b0;
  logic          wr_ack;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] m_mem [DEPTH];
  logic          m_valid [DEPTH];
  logic [AW-1:0] m_addr = '0;
  int            m_cnt = 0;
  logic          m_req_q = 1'b0;
  int            clear_left = 0;
  exp_t          exp_q [$];

  ram_scan_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SCAN_PERIOD(PERIOD)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_req  (wr_req),
    .wr_ack  (wr_ack),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Advance the reference model by one edge, queue what the DUT must show, then clock.
  task automatic run_cycle();
    exp_t e;
    if (!reset) begin
      e.chk_rd = 1'b1; e.rd = '0; e.addr = '0; e.ack = 1'b0;
      e.busy = (CLEAR_CYCLES > 0);
      m_addr = '0; m_cnt = 0; m_req_q = 1'b0; clear_left = CLEAR_CYCLES;
      if (CLEAR_CYCLES > 0) begin
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_valid[i] = 1'b1; end
      end
    end else if (clear_left > 0) begin
      e.chk_rd = 1'b0; e.rd = '0; e.addr = '0; e.ack = 1'b0;
      clear_left--;
      e.busy = (clear_left > 0);
      m_req_q = wr_req;
    end else begin
      e.chk_rd = m_valid[m_addr];
      e.rd = m_mem[m_addr];
      e.ack = wr_req && !m_req_q;
      if (e.ack) begin m_mem[wr_addr] = wr_data; m_valid[wr_addr] = 1'b1; end
      if (m_cnt == PERIOD - 1) begin m_cnt = 0; m_addr = m_addr + 1'b1; end
      else m_cnt++;
      e.addr = m_addr; e.busy = 1'b0;
      m_req_q = wr_req;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_clear();
    exp_t e;
    int busy_cnt;
    reset = 1'b0; wr_req = 1'b0;
    repeat (2) begin
      run_cycle(); e = exp_q.pop_front();
      tests++; if (rd_addr !== 5'h00) begin fails++; $display("[TB] FAIL reset_rd_addr: got %h expected 00", rd_addr); end
      tests++; if (rd_data !== 4'h0) begin fails++; $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data); end
      tests++; if (wr_ack !== 1'b0) begin fails++; $display("[TB] FAIL reset_wr_ack: got %b expected 0", wr_ack); end
      tests++; if (busy !== e.busy) begin fails++; $display("[TB] FAIL reset_busy: got %b expected %b", busy, e.busy); end
    end
    reset = 1'b1;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    repeat (40) begin
      run_cycle(); e = exp_q.pop_front();
      if (busy === 1'b1) busy_cnt++;
      tests++; if (busy !== e.busy) begin fails++; $display("[TB] FAIL clear_busy: got %b expected %b", busy, e.busy); end
    end
    tests++; if (busy_cnt != CLEAR_CYCLES) begin fails++; $display("[TB] FAIL clear_busy_len: got %0d expected %0d", busy_cnt, CLEAR_CYCLES); end
`ifndef RAM_SCAN_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      wr_addr = AW'(i); wr_data = '0; wr_req = 1'b1;
      run_cycle(); e = exp_q.pop_front();
      tests++; if (wr_ack !== e.ack) begin fails++; $display("[TB] FAIL init_ack: got %b expected %b", wr_ack, e.ack); end
      wr_req = 1'b0;
      run_cycle(); e = exp_q.pop_front();
    end
`endif
    repeat (DEPTH * PERIOD) begin
      run_cycle(); e = exp_q.pop_front();
      tests++; if (rd_addr !== e.addr) begin fails++; $display("[TB] FAIL scan_addr: got %h expected %h", rd_addr, e.addr); end
      if (e.chk_rd) begin
        tests++; if (rd_data !== e.rd) begin fails++; $display("[TB] FAIL clear_rd_data: got %h expected %h", rd_data, e.rd); end
      end
    end
  endtask

  task automatic test_single_write();
    exp_t e;
    int ack_cnt = 0;
    int hits = 0;
    logic [AW-1:0] prev_addr;
    wr_addr = 5'h0A; wr_data = 4'hA; wr_req = 1'b1;
    repeat (10) begin
      run_cycle(); e = exp_q.pop_front();
      if (wr_ack === 1'b1) ack_cnt++;
      tests++; if (wr_ack !== e.ack) begin fails++; $display("[TB] FAIL write_ack: got %b expected %b", wr_ack, e.ack); end
    end
    tests++; if (ack_cnt != 1) begin fails++; $display("[TB] FAIL write_ack_count: got %0d expected 1", ack_cnt); end
    wr_req = 1'b0;
    prev_addr = m_addr;
    repeat (DEPTH * PERIOD) begin
      run_cycle(); e = exp_q.pop_front();
      if (prev_addr == 5'h0A && rd_data === 4'hA) hits++;
      if (e.chk_rd) begin
        tests++; if (rd_data !== e.rd) begin fails++; $display("[TB] FAIL write_rd_data: got %h expected %h", rd_data, e.rd); end
      end
      prev_addr = e.addr;
    end
    tests++; if (hits != PERIOD) begin fails++; $display("[TB] FAIL write_readback: got %0d cycles expected %0d", hits, PERIOD); end
  endtask

  task automatic test_scan_wrap();
    exp_t e;
    int guard = 0;
    while (!(m_addr == 5'h1F && m_cnt == 0) && guard < 300) begin
      run_cycle(); e = exp_q.pop_front(); guard++;
    end
    tests++; if (guard >= 300) begin fails++; $display("[TB] FAIL wrap_wait: got %0d cycles expected under 300", guard); end
    repeat (3) begin run_cycle(); e = exp_q.pop_front(); end
    tests++; if (rd_addr !== 5'h1F) begin fails++; $display("[TB] FAIL wrap_hold: got %h expected 1f", rd_addr); end
    run_cycle(); e = exp_q.pop_front();
    tests++; if (rd_addr !== 5'h00) begin fails++; $display("[TB] FAIL wrap_zero: got %h expected 00", rd_addr); end
    repeat (4) begin run_cycle(); e = exp_q.pop_front(); end
    tests++; if (rd_addr !== 5'h01) begin fails++; $display("[TB] FAIL wrap_one: got %h expected 01", rd_addr); end
  endtask

  task automatic test_collision();
    exp_t e;
    int guard = 0;
    logic [AW-1:0] a;
    logic [DW-1:0] old;
    while (m_cnt != 0 && guard < 10) begin run_cycle(); e = exp_q.pop_front(); guard++; end
    a = m_addr; old = m_mem[a];
    wr_addr = a; wr_data = 4'h5; wr_req = 1'b1;
    run_cycle(); e = exp_q.pop_front();
    tests++; if (rd_data !== old) begin fails++; $display("[TB] FAIL collide_old: got %h expected %h", rd_data, old); end
    wr_req = 1'b0;
    run_cycle(); e = exp_q.pop_front();
    tests++; if (rd_data !== 4'h5) begin fails++; $display("[TB] FAIL collide_new: got %h expected 5", rd_data); end
    guard = 0;
    while (m_cnt != PERIOD - 1 && guard < 10) begin run_cycle(); e = exp_q.pop_front(); guard++; end
    old = m_mem[m_addr]; a = m_addr + 1'b1;
    wr_addr = a; wr_data = 4'h7; wr_req = 1'b1;
    run_cycle(); e = exp_q.pop_front();
    tests++; if (rd_addr !== a) begin fails++; $display("[TB] FAIL tick_write_addr: got %h expected %h", rd_addr, a); end
    tests++; if (rd_data !== old) begin fails++; $display("[TB] FAIL tick_write_old: got %h expected %h", rd_data, old); end
    wr_req = 1'b0;
    run_cycle(); e = exp_q.pop_front();
    tests++; if (rd_data !== 4'h7) begin fails++; $display("[TB] FAIL tick_write_new: got %h expected 7", rd_data); end
  endtask

  task automatic test_key_held();
    exp_t e;
    int ack_cnt = 0;
    wr_addr = 5'h03; wr_data = 4'hF; wr_req = 1'b1; reset = 1'b0;
    repeat (2) begin run_cycle(); e = exp_q.pop_front(); end
    reset = 1'b1;
    repeat (40) begin
      run_cycle(); e = exp_q.pop_front();
      if (wr_ack === 1'b1) ack_cnt++;
    end
    tests++; if (ack_cnt != ((CLEAR_CYCLES > 0) ? 0 : 1)) begin fails++; $display("[TB] FAIL held_key_ack: got %0d expected %0d", ack_cnt, (CLEAR_CYCLES > 0) ? 0 : 1); end
    ack_cnt = 0;
    wr_req = 1'b0;
    run_cycle(); e = exp_q.pop_front();
    wr_req = 1'b1;
    repeat (5) begin
      run_cycle(); e = exp_q.pop_front();
      if (wr_ack === 1'b1) ack_cnt++;
    end
    tests++; if (ack_cnt != 1) begin fails++; $display("[TB] FAIL repress_ack: got %0d expected 1", ack_cnt); end
    wr_req = 1'b0;
    repeat (DEPTH * PERIOD) begin
      run_cycle(); e = exp_q.pop_front();
      if (e.chk_rd) begin
        tests++; if (rd_data !== e.rd) begin fails++; $display("[TB] FAIL held_rd_data: got %h expected %h", rd_data, e.rd); end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    int busy_cnt;
    reset = 1'b0;
    run_cycle(); e = exp_q.pop_front();
    reset = 1'b1;
    repeat (10) begin run_cycle(); e = exp_q.pop_front(); end
    reset = 1'b0;
    run_cycle(); e = exp_q.pop_front();
    tests++; if (busy !== e.busy) begin fails++; $display("[TB] FAIL midreset_busy: got %b expected %b", busy, e.busy); end
    reset = 1'b1;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    repeat (40) begin
      run_cycle(); e = exp_q.pop_front();
      if (busy === 1'b1) busy_cnt++;
    end
    tests++; if (busy_cnt != CLEAR_CYCLES) begin fails++; $display("[TB] FAIL midreset_busy_len: got %0d expected %0d", busy_cnt, CLEAR_CYCLES); end
    repeat (DEPTH * PERIOD) begin
      run_cycle(); e = exp_q.pop_front();
      tests++; if (rd_addr !== e.addr) begin fails++; $display("[TB] FAIL midreset_addr: got %h expected %h", rd_addr, e.addr); end
      if (e.chk_rd) begin
        tests++; if (rd_data !== e.rd) begin fails++; $display("[TB] FAIL midreset_rd_data: got %h expected %h", rd_data, e.rd); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_valid[i] = 1'b0; end
    @(posedge clk);
    #1;
    test_reset_clear();
    test_single_write();
    test_scan_wrap();
    test_collision();
    test_key_held();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_scan_ctrl.md
# ram_scan_ctrl

Parametrised successor to the board-level single-port RAM test wrapper. It holds a 2**ADDR_WIDTH × DATA_WIDTH dual-port memory with two independent ports:
- a write port driven by switch/key inputs, one write per key press;
- a read port that scans every address automatically, advancing once per SCAN_PERIOD clocks.

It sits between the metastability filters and the seg7 drivers in the DE1_SoC top level, replacing the manually clocked RAM.

## Interface
- ADDR_WIDTH, 5: address bits; depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 4: word width.
- SCAN_PERIOD, 50_000_000: clocks per read-address advance; legal values ≥ 1.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-low reset.
- wr_addr  in  ADDR_WIDTH  write address, already filtered.
- wr_data  in  DATA_WIDTH  write data, already filtered.
- wr_req  in  1  level write request (key pressed = 1); one write per rising edge.
- wr_ack  out  1  one-cycle pulse, the cycle after a write is committed.
- rd_addr  out  ADDR_WIDTH  current scan address.
- rd_data  out  DATA_WIDTH  registered contents of mem[rd_addr].
- busy  out  1  high while the init clear sweep runs; constant 0 without RAM_SCAN_CLEAR_EN.

## Operation
- Edge detect: wr_req_q is the registered copy of wr_req. A write fires when wr_req=1 and wr_req_q=0, state is RUN, and reset is deasserted.
- Write: mem[wr_addr] <= wr_data at that clock edge. wr_ack=1 in the following cycle only. Holding wr_req high never repeats the write.
- Scan counter:
  - Counts 0..SCAN_PERIOD-1, then returns to 0; that wrap is the tick.
  - On tick, rd_addr <= rd_addr + 1, modulo DEPTH (DEPTH-1 → 0).
  - Counter width is max(1, $clog2(SCAN_PERIOD)).
  - SCAN_PERIOD=1 gives a tick every cycle.
- Read: rd_data <= mem[rd_addr] every cycle, read-before-write. If a write hits rd_addr in cycle k, rd_data shows the old word after edge k and the new word after edge k+1.
- FSM states: CLEAR, RUN.
  - reset=0 → CLEAR if RAM_SCAN_CLEAR_EN is defined, else RUN.
  - CLEAR → RUN after the write to address DEPTH-1.
  - RUN has no exit except reset.
- In CLEAR:
  - clr_addr walks 0..DEPTH-1, one zero-write per cycle.
  - Scan counter and rd_addr are held at 0.
  - wr_req edges are discarded, but wr_req_q still tracks wr_req, so a key held through CLEAR does not fire on entry to RUN.

## Timing
- Values while reset=0: rd_addr=0, scan counter=0, rd_data=0, wr_ack=0, wr_req_q=0, clr_addr=0.
- busy is 1 while reset=0 with RAM_SCAN_CLEAR_EN defined, 0 without.
- Memory contents are not reset without RAM_SCAN_CLEAR_EN.
- Write latency: memory updated at the edge that detects wr_req rising; wr_ack high the next cycle.
- Read latency: 1 clock from rd_addr change to rd_data valid.
- Scan: after reset release in RUN, the first rd_addr change happens at the SCAN_PERIOD-th edge.
- Clear sweep: busy stays high for exactly DEPTH cycles after reset release, then falls. The first scan tick comes SCAN_PERIOD cycles after that.
- Reset mid-operation (any state): returns to the reset values above on the next edge; an in-progress CLEAR restarts at address 0. A write detected in the same cycle that reset is asserted is dropped.
- Simultaneous write and scan tick: both take effect. The read uses the pre-tick rd_addr for that cycle.

## Configuration
- RAM_SCAN_CLEAR_EN defined:
  - CLEAR state and clr_addr compiled in.
  - Every reset zero-fills the memory over DEPTH cycles with busy=1.
- RAM_SCAN_CLEAR_EN undefined:
  - No CLEAR state; FSM resets straight to RUN.
  - busy tied to 0.
  - Memory power-up contents are undefined (X in simulation).

## Structure
- Package ram_scan_pkg holds:
  - state_t enum {CLEAR, RUN};
  - the SCAN_PERIOD default as a localparam, shared by the DE1_SoC top and the bench;
  - a helper cnt_width(period) returning max(1, $clog2(period)).
- Sub-module ram_scan_dp_mem:
  - one write port (we, waddr, wdata) and one registered read port (raddr, rdata), read-before-write;
  - infers block RAM;
  - write port muxed between the clear path and the user path in ram_scan_ctrl.
- ram_scan_ctrl holds the FSM, edge detect, scan counter and wr_ack.

## Test plan
Bench parameters: ADDR_WIDTH=5, DATA_WIDTH=4, SCAN_PERIOD=4, RAM_SCAN_CLEAR_EN defined.
- Reset and clear: hold reset=0 for 2 cycles, release → busy=1 for exactly 32 cycles then 0. Then rd_data=0 at every address over one full 128-cycle scan.
- Single write: wr_addr=5'h0A, wr_data=4'hA, raise wr_req and hold it 10 cycles → exactly one wr_ack pulse. When rd_addr=5'h0A, rd_data=4'hA one cycle later.
- Scan wrap: run 32×4 cycles from rd_addr=5'h1F at counter 0 → rd_addr goes to 5'h00 after 4 edges, then 5'h01 after 4 more.
- Collision: write 4'h5 to the current rd_addr with the scan counter at 0 → rd_data shows the old value for 1 cycle, then 4'h5.
- Key held through clear: wr_req=1 before reset release and kept high → no write and no wr_ack after busy falls. Drop and re-raise wr_req → one write.
- Reset mid-clear: assert reset at clear cycle 10 for 1 cycle → busy stays high a further 32 cycles after release, and all addresses read 0.
